// File: rtl/out1_reader.sv
// Streams one frame of DEPTH words out of a synchronous-read RAM with valid/ready
// backpressure, tracking the largest word seen and where it came from.
module out1_reader #(
  parameter int unsigned DEPTH = 50,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_index,
  output logic [DW-1:0] max_val,
  output logic [AW-1:0] max_idx
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic            inflight_q;
  logic [DW-1:0]   fifo_data_q [2];
  logic [DW-1:0]   fifo_data_d [2];
  logic [AW-1:0]   fifo_idx_q  [2];
  logic [AW-1:0]   fifo_idx_d  [2];
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [DW-1:0]   max_val_q;
  logic [AW-1:0]   max_idx_q;

  logic            pop, issue, last_hs, start_acc;
  logic [1:0]      load;

  assign m_valid   = (fifo_cnt_q != 2'd0);
  assign m_data    = fifo_data_q[0];
  assign m_index   = fifo_idx_q[0];
  assign pop       = m_valid && m_ready;
  assign start_acc = (state_q == StIdle) && start;
  assign last_hs   = (state_q == StRun) && pop && (m_index == AW'(DEPTH - 1));

  // Occupancy counts the word leaving this cycle as gone, so a full-rate stream
  // keeps one read in flight behind one buffered word.
  assign load  = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = (state_q == StRun) && (cnt_q < CW'(DEPTH)) && (load < 2'd2);

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

  always_comb begin
    if (issue) begin
      ram_addr = AW'(cnt_q);
    end else if (state_q == StIdle) begin
      ram_addr = '0;
    end else begin
      ram_addr = addr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_hs) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pop shifts the tail into the head; the returning read lands behind what is left.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_idx_d[0]  = fifo_idx_q[1];
      fifo_cnt_d     = fifo_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      fifo_data_d[fifo_cnt_d[0]] = ram_dout;
      fifo_idx_d[fifo_cnt_d[0]]  = addr_q;
      fifo_cnt_d                 = fifo_cnt_d + 2'd1;
    end
    if (start_acc) begin
      fifo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      fifo_data_q <= fifo_data_d;
      fifo_idx_q  <= fifo_idx_d;
      fifo_cnt_q  <= fifo_cnt_d;
      inflight_q  <= issue;
      if (issue) begin
        cnt_q  <= cnt_q + CW'(1);
        addr_q <= AW'(cnt_q);
      end
      if (pop && (m_data > max_val_q)) begin
        max_val_q <= m_data;
        max_idx_q <= m_index;
      end
      if (start_acc) begin
        cnt_q      <= '0;
        addr_q     <= '0;
        inflight_q <= 1'b0;
        max_val_q  <= '0;
        max_idx_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_out1_reader.sv
// Scoreboard bench for out1_reader: stimulus queues expected words per frame, a
// negedge monitor pops and compares on every handshake.
module tb_out1_reader;

  localparam int unsigned DEPTH = 50;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 9;

  logic          clk = 1'b0;
  logic          rst, start, m_ready;
  logic          busy, done, m_valid;
  logic [AW-1:0] ram_addr, m_index, max_idx;
  logic [DW-1:0] ram_dout, m_data, max_val;

  out1_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .max_val  (max_val),
    .max_idx  (max_idx)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] sb [$];
  int hs_count, done_cnt, first_hs, last_hs;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  initial begin
    logic          stall;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_i;
    logic [AW+DW-1:0] e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (m_valid) begin
          if (stall) begin
            chk("hold_data", m_data, hold_d);
            chk("hold_index", m_index, hold_i);
          end
          if (m_ready) begin
            if (sb.size() == 0) begin
              chk("extra_word", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("m_data", m_data, e[DW-1:0]);
              chk("m_index", m_index, e[AW+DW-1:DW]);
            end
            if (hs_count == 0) first_hs = cyc;
            last_hs = cyc;
            hs_count++;
            stall = 1'b0;
          end else begin
            stall  = 1'b1;
            hold_d = m_data;
            hold_i = m_index;
          end
        end else begin
          stall = 1'b0;
        end
        if (done) begin
          done_cnt++;
          chk("done_latency", cyc, last_hs + 1);
        end
      end
    end
  end

  task automatic new_frame();
    sb.delete();
    hs_count = 0;
    done_cnt = 0;
    first_hs = 0;
    last_hs  = -10;
    for (int i = 0; i < DEPTH; i++) sb.push_back({AW'(i), mem[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int exp_max, input int exp_idx);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt > 0), 1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_words"}, hs_count, DEPTH);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_max_val"}, max_val, exp_max);
    chk({tag, "_max_idx"}, max_idx, exp_idx);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_addr"}, ram_addr, 0);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = DW'(i * 5);
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    hs_count = 0; done_cnt = 0; last_hs = -10;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_max_idx", max_idx, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full-rate frame: latency and throughput.
    ready_mode = 0;
    new_frame();
    pulse_start();
    @(negedge clk);
    chk("lat_busy", busy, 1);
    chk("lat_valid_c1", m_valid, 0);
    @(negedge clk);
    chk("lat_valid_c2", m_valid, 0);
    @(negedge clk);
    chk("lat_valid_c3", m_valid, 1);
    finish_frame("full", 245, 49);
    chk("throughput", last_hs - first_hs, DEPTH - 1);

    // Random backpressure.
    ready_mode = 1;
    new_frame();
    pulse_start();
    finish_frame("rand", 245, 49);

    // Tie on maximum keeps the lower index.
    mem[7]  = 9'd300;
    mem[31] = 9'd300;
    ready_mode = 0;
    new_frame();
    pulse_start();
    finish_frame("tie", 300, 7);
    for (int i = 0; i < 64; i++) mem[i] = DW'(i * 5);

    // Reset mid-frame after 20 handshakes.
    new_frame();
    pulse_start();
    n = 0;
    while (hs_count < 20 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("abort_reached20", (hs_count >= 20), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_max_val", max_val, 0);
    chk("abort_addr", ram_addr, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    // Start coincident with reset is ignored.
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    chk("start_in_rst_busy", busy, 0);
    new_frame();
    pulse_start();
    finish_frame("restart", 245, 49);

    // Start pulses while busy do nothing.
    ready_mode = 1;
    new_frame();
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    repeat (30) @(posedge clk);
    pulse_start();
    finish_frame("restart_busy", 245, 49);

    // Downstream stall right after first valid.
    ready_mode = 2;
    new_frame();
    pulse_start();
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_first_valid", m_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_addr_hold", ram_addr, 1);
      chk("stall_valid_hold", m_valid, 1);
      @(negedge clk);
    end
    ready_mode = 0;
    finish_frame("stall", 245, 49);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out1_reader.md
OUT1_READER -- requirements
Module: out1_reader

Interface
REQ-001 Clock and reset are `clk` and `rst`: one clock, synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 50: number of result words read per frame.
REQ-003 Parameter AW, default 6: RAM address width.
REQ-004 Parameter DW, default 9: RAM data width.
REQ-005 Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to read one frame.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last word is accepted downstream.
- ram_addr  output  AW  drives the read address of the 50x9 output RAM (addrb); the RAM is sampled on the same clk.
- ram_dout  input  DW  RAM read data (dob), valid one cycle after ram_addr is sampled.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DW  stream word, unsigned.
- m_index  output  AW  address the current m_data came from.
- max_val  output  DW  largest word accepted in the current/last frame.
- max_idx  output  AW  index of max_val.

Function
REQ-006 FSM states:
- IDLE -> RUN on start.
- RUN -> DONE when word DEPTH-1 is handshaken.
- DONE -> IDLE unconditionally after 1 cycle; done is high only in DONE.
REQ-007 busy is high only in RUN.
REQ-008 start is ignored in RUN and DONE.
REQ-009 On the start edge:
- issue counter = 0
- max_val = 0, max_idx = 0
- internal buffer emptied
REQ-010 Read issue: in a RUN cycle where issue counter < DEPTH and (buffer occupancy + in-flight reads) < 2:
- ram_addr = issue counter
- counter increments
- in-flight flag set for exactly the next cycle
REQ-011 In the cycle after an issue, ram_dout and the issued address are pushed into a 2-entry FIFO. No RAM word is ever lost or duplicated.
REQ-012 m_valid = FIFO non-empty. m_data and m_index are the FIFO head and stay stable while m_valid && !m_ready.
REQ-013 Throughput: with m_ready held high, one word per cycle after a 2-cycle initial latency. The first m_valid is 2 cycles after the start edge.
REQ-014 Simultaneous FIFO push and pop in one cycle is legal; occupancy is unchanged.
REQ-015 Word order on the stream is strictly index 0..DEPTH-1.
REQ-016 Max tracking on each handshake: if m_data > max_val (unsigned, strict), then max_val = m_data and max_idx = m_index. Ties keep the earlier (lower) index.
REQ-017 max_val and max_idx hold their final values after DONE until the next accepted start.
REQ-018 ram_addr holds its last value when no read is issued, and is 0 in IDLE.
REQ-019 m_ready high while m_valid is low has no effect.

Reset
REQ-020 In the cycle after rst is sampled high, regardless of state:
- state = IDLE
- busy = 0, done = 0, m_valid = 0
- ram_addr = 0, m_data = 0, m_index = 0
- max_val = 0, max_idx = 0
- FIFO empty, in-flight flag clear, issue counter = 0
REQ-021 rst mid-frame aborts the frame with no done pulse. A start asserted together with rst is ignored.

Verification
REQ-022 RAM model preloaded with word[i] = i*5 (i = 0..49), m_ready = 1, single start:
- 50 words 0,5,...,245 with m_index 0..49
- one word per cycle
- done 1 cycle after the index-49 handshake
- max_val = 245, max_idx = 49
REQ-023 Random m_ready (50% duty), same data:
- identical stream order and values
- m_data stable whenever valid is held without ready
- no drops or duplicates
- done pulse exactly once
REQ-024 word[7] = 300, word[31] = 300, all others < 300:
- max_val = 300, max_idx = 7 (tie keeps lower index)
REQ-025 rst asserted after 20 handshakes:
- next cycle busy = 0, m_valid = 0, max_val = 0
- no done pulse
- a new start reads the full 50 words from index 0
REQ-026 start pulsed again while busy:
- no effect on the stream
- exactly 50 words and one done
REQ-027 m_ready held 0 for 10 cycles after the first valid:
- FIFO fills to 2, no further reads are issued, ram_addr holds at 1
- on release, words 0,1,2... continue in order
